// File: rtl/fmac_seq_ctrl_if.sv
// Handshake and control bundle between the MAC issue sequencer and its user.
// master = job owner / operand source / result consumer, slave = sequencer.
interface fmac_seq_ctrl_if #(
   parameter int STAGES = 4,
   parameter int CNT_W  = 16
);
   logic              start;
   logic [CNT_W-1:0]  len;
   logic              clr_acc;
   logic              abort;
   logic              in_valid;
   logic              in_ready;
   logic [STAGES-1:0] stage_en;
   logic              acc_clr;
   logic              acc_we;
   logic              out_valid;
   logic              out_ready;
   logic              busy;
   logic              done;
   logic [CNT_W-1:0]  op_count;

   modport master (
      output start, len, clr_acc, abort, in_valid, out_ready,
      input  in_ready, stage_en, acc_clr, acc_we, out_valid, busy, done, op_count
   );

   modport slave (
      input  start, len, clr_acc, abort, in_valid, out_ready,
      output in_ready, stage_en, acc_clr, acc_we, out_valid, busy, done, op_count
   );
endinterface

// File: rtl/fmac_seq_ctrl.sv
// Issue sequencer for the FP MAC pipeline: one operand pair per STAGES cycles,
// per-stage enables from a valid shift register, job counting and result handshake.
module fmac_seq_ctrl #(
   parameter int STAGES = 4,
   parameter int CNT_W  = 16
) (
   input  logic                 clock,
   input  logic                 resetn,
   fmac_seq_ctrl_if.slave       bus
);
   typedef enum logic [1:0] {IDLE, RUN, DRAIN, RESULT} state_t;

   state_t            state_q;
   logic [STAGES-1:0] vpipe_q;
   logic [CNT_W-1:0]  len_q;
   logic [CNT_W-1:0]  op_cnt_q;
   logic              acc_clr_q;
   logic              out_valid_q;
   logic              done_q;
   logic              in_ready;
   logic              accept;

   // Only the last stage may be occupied when issuing, so the accumulator
   // write-back of the previous op lands before the next op reads it.
   assign in_ready = (state_q == RUN) && (vpipe_q[STAGES-2:0] == '0) && (op_cnt_q < len_q);
   assign accept   = bus.in_valid && in_ready;

   always_ff @(posedge clock or negedge resetn) begin
      if (!resetn) begin
         state_q     <= IDLE;
         vpipe_q     <= '0;
         len_q       <= '0;
         op_cnt_q    <= '0;
         acc_clr_q   <= 1'b0;
         out_valid_q <= 1'b0;
         done_q      <= 1'b0;
      end else begin
         acc_clr_q <= 1'b0;
         done_q    <= 1'b0;
         if (bus.abort) begin
            state_q     <= IDLE;
            vpipe_q     <= '0;
            out_valid_q <= 1'b0;
         end else begin
            vpipe_q <= {vpipe_q[STAGES-2:0], accept};
            case (state_q)
               IDLE: begin
                  if (bus.start) begin
                     len_q       <= bus.len;
                     op_cnt_q    <= '0;
                     acc_clr_q   <= bus.clr_acc;
                     // An empty job goes straight to presenting the accumulator.
                     state_q     <= (bus.len != '0) ? RUN : RESULT;
                     out_valid_q <= (bus.len == '0);
                  end
               end
               RUN: begin
                  if (accept) begin
                     op_cnt_q <= op_cnt_q + CNT_W'(1);
                     if (op_cnt_q + CNT_W'(1) == len_q) state_q <= DRAIN;
                  end
               end
               DRAIN: begin
                  if (vpipe_q == '0) begin
                     state_q     <= RESULT;
                     out_valid_q <= 1'b1;
                  end
               end
               RESULT: begin
                  if (bus.out_ready) begin
                     state_q     <= IDLE;
                     out_valid_q <= 1'b0;
                     done_q      <= 1'b1;
                  end
               end
               default: state_q <= IDLE;
            endcase
         end
      end
   end

   assign bus.in_ready  = in_ready;
   assign bus.stage_en  = vpipe_q;
   assign bus.acc_we    = vpipe_q[STAGES-1];
   assign bus.acc_clr   = acc_clr_q;
   assign bus.out_valid = out_valid_q;
   assign bus.busy      = (state_q != IDLE);
   assign bus.done      = done_q;
   assign bus.op_count  = op_cnt_q;
endmodule

// File: tb/tb_fmac_seq_ctrl.sv
// Directed bench for fmac_seq_ctrl (STAGES=4): reset, full job, empty job,
// result backpressure, abort and gappy input, with hand-derived cycle timing.
module tb_fmac_seq_ctrl;
   localparam int STAGES = 4;
   localparam int CNT_W  = 16;

   logic clk = 1'b0;
   logic rst_n = 1'b0;
   int   n_vec = 0;
   int   n_err = 0;

   fmac_seq_ctrl_if #(.STAGES(STAGES), .CNT_W(CNT_W)) bus();

   fmac_seq_ctrl #(.STAGES(STAGES), .CNT_W(CNT_W)) dut (
      .clock  (clk),
      .resetn (rst_n),
      .bus    (bus.slave)
   );

   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_vec++;
      if (got !== exp) begin
         n_err++;
         $display("FAIL %s: got %0h expected %0h", tag, got, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic idle_inputs();
      bus.start     = 1'b0;
      bus.len       = '0;
      bus.clr_acc   = 1'b0;
      bus.abort     = 1'b0;
      bus.in_valid  = 1'b0;
      bus.out_ready = 1'b0;
   endtask

   // Cycle 0 of a job: start presented with operands already valid.
   task automatic kick(input int l, input logic c);
      bus.start    = 1'b1;
      bus.len      = CNT_W'(l);
      bus.clr_acc  = c;
      bus.in_valid = 1'b1;
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: simulation did not complete");
      $fatal(1);
   end

   initial begin
      logic [STAGES-1:0] exp_se;
      int acc_t[3];
      int cnt;

      idle_inputs();
      tick(); tick();
      chk("rst_busy", 32'(bus.busy), 0);
      chk("rst_stage_en", 32'(bus.stage_en), 0);
      rst_n = 1'b1;
      tick();

      // T1: asynchronous reset mid-job
      kick(3, 1'b0);
      tick(); bus.start = 1'b0;
      tick(); tick(); tick();
      chk("t1_pre_stage_en", 32'(bus.stage_en), 32'h4);
      chk("t1_pre_busy", 32'(bus.busy), 1);
      #2 rst_n = 1'b0;
      #1;
      chk("t1_stage_en", 32'(bus.stage_en), 0);
      chk("t1_acc_we", 32'(bus.acc_we), 0);
      chk("t1_acc_clr", 32'(bus.acc_clr), 0);
      chk("t1_out_valid", 32'(bus.out_valid), 0);
      chk("t1_busy", 32'(bus.busy), 0);
      chk("t1_done", 32'(bus.done), 0);
      chk("t1_op_count", 32'(bus.op_count), 0);
      chk("t1_in_ready", 32'(bus.in_ready), 0);
      tick();
      rst_n = 1'b1;
      tick();
      chk("t1_post_busy", 32'(bus.busy), 0);
      chk("t1_post_in_ready", 32'(bus.in_ready), 0);
      idle_inputs();
      tick();

      // T2: len=3, clr_acc, in_valid held high
      acc_t = '{1, 5, 9};
      kick(3, 1'b1);
      for (int c = 1; c <= 17; c++) begin
         tick();
         bus.start     = 1'b0;
         bus.out_ready = (c == 15);
         exp_se = '0;
         for (int a = 0; a < 3; a++)
            for (int i = 0; i < STAGES; i++)
               if (c == acc_t[a] + 1 + i) exp_se[i] = 1'b1;
         chk($sformatf("t2_acc_clr_c%0d", c),   32'(bus.acc_clr),   32'(c == 1));
         chk($sformatf("t2_in_ready_c%0d", c),  32'(bus.in_ready),  32'(c == 1 || c == 5 || c == 9));
         chk($sformatf("t2_acc_we_c%0d", c),    32'(bus.acc_we),    32'(c == 5 || c == 9 || c == 13));
         chk($sformatf("t2_stage_en_c%0d", c),  32'(bus.stage_en),  32'(exp_se));
         chk($sformatf("t2_out_valid_c%0d", c), 32'(bus.out_valid), 32'(c == 15));
         chk($sformatf("t2_busy_c%0d", c),      32'(bus.busy),      32'(c <= 15));
         chk($sformatf("t2_done_c%0d", c),      32'(bus.done),      32'(c == 16));
         chk($sformatf("t2_op_count_c%0d", c),  32'(bus.op_count),
             32'((c >= 2) + (c >= 6) + (c >= 10)));
      end
      idle_inputs();
      tick();

      // T3: empty job
      kick(0, 1'b1);
      tick();
      idle_inputs();
      chk("t3_acc_clr", 32'(bus.acc_clr), 1);
      chk("t3_out_valid", 32'(bus.out_valid), 1);
      chk("t3_stage_en", 32'(bus.stage_en), 0);
      chk("t3_acc_we", 32'(bus.acc_we), 0);
      chk("t3_in_ready", 32'(bus.in_ready), 0);
      bus.out_ready = 1'b1;
      tick();
      bus.out_ready = 1'b0;
      chk("t3_done", 32'(bus.done), 1);
      chk("t3_busy", 32'(bus.busy), 0);
      chk("t3_out_valid_off", 32'(bus.out_valid), 0);
      chk("t3_stage_en2", 32'(bus.stage_en), 0);
      tick();
      chk("t3_done_once", 32'(bus.done), 0);

      // T4: result backpressure, start ignored while busy
      kick(3, 1'b0);
      cnt = 0;
      do begin
         tick();
         cnt++;
         bus.start = 1'b0;
      end while (!bus.out_valid && cnt < 60);
      chk("t4_latency", 32'(cnt), 15);
      bus.in_valid = 1'b0;
      for (int k = 0; k < 5; k++) begin
         chk($sformatf("t4_out_valid_k%0d", k), 32'(bus.out_valid), 1);
         chk($sformatf("t4_busy_k%0d", k), 32'(bus.busy), 1);
         chk($sformatf("t4_op_count_k%0d", k), 32'(bus.op_count), 3);
         chk($sformatf("t4_done_k%0d", k), 32'(bus.done), 0);
         bus.start = (k == 1);
         bus.len   = CNT_W'(7);
         tick();
      end
      bus.start     = 1'b0;
      bus.out_ready = 1'b1;
      chk("t4_out_valid_hs", 32'(bus.out_valid), 1);
      tick();
      bus.out_ready = 1'b0;
      chk("t4_done", 32'(bus.done), 1);
      chk("t4_busy", 32'(bus.busy), 0);
      chk("t4_op_count", 32'(bus.op_count), 3);
      tick();
      chk("t4_done_once", 32'(bus.done), 0);
      chk("t4_op_count_hold", 32'(bus.op_count), 3);
      idle_inputs();

      // T5: abort in cycle 6 of a len=3 job, together with start
      kick(3, 1'b1);
      for (int c = 1; c <= 6; c++) begin
         tick();
         bus.start = 1'b0;
      end
      chk("t5_pre_stage_en", 32'(bus.stage_en), 32'h1);
      bus.abort = 1'b1;
      bus.start = 1'b1;
      tick();
      bus.abort = 1'b0;
      bus.start = 1'b0;
      chk("t5_busy", 32'(bus.busy), 0);
      chk("t5_stage_en", 32'(bus.stage_en), 0);
      chk("t5_in_ready", 32'(bus.in_ready), 0);
      chk("t5_acc_we", 32'(bus.acc_we), 0);
      chk("t5_out_valid", 32'(bus.out_valid), 0);
      for (int c = 8; c <= 12; c++) begin
         tick();
         chk($sformatf("t5_done_c%0d", c), 32'(bus.done), 0);
         chk($sformatf("t5_busy_c%0d", c), 32'(bus.busy), 0);
      end
      idle_inputs();

      // T6: gappy input, len=2
      kick(2, 1'b0);
      bus.in_valid = 1'b0;
      for (int c = 1; c <= 16; c++) begin
         tick();
         bus.start     = 1'b0;
         bus.in_valid  = (c >= 4);
         bus.out_ready = (c == 14);
         chk($sformatf("t6_in_ready_c%0d", c), 32'(bus.in_ready), 32'(c <= 4 || c == 8));
         chk($sformatf("t6_op_count_c%0d", c), 32'(bus.op_count), 32'((c >= 5) + (c >= 9)));
         chk($sformatf("t6_acc_we_c%0d", c), 32'(bus.acc_we), 32'(c == 8 || c == 12));
         chk($sformatf("t6_out_valid_c%0d", c), 32'(bus.out_valid), 32'(c == 14));
         chk($sformatf("t6_done_c%0d", c), 32'(bus.done), 32'(c == 15));
      end
      idle_inputs();
      tick();

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end
endmodule
